// File: rtl/la_trig_capture.sv
// la_trig_capture -- trigger-and-capture logic analyzer on the com link.
// While armed, the DW-bit probe bus is written every rdclk into a 2^AW-deep
// circular buffer. A masked level/edge match, or a software FORCE, marks the
// trigger sample. A clamped number of post-trigger samples is then taken and
// the buffer freezes. The frozen window is popped oldest-first at MYAD.
//
// Ports:
//   rdclk    sole clock (probe and com link are synchronous to it)
//   rst      asynchronous active-low reset
//   Data     probe bus, DW bits
//   DataIn   com-link write data
//   Address  com-link address
//   Read     read strobe (may be held several cycles)
//   Write    write strobe
//   DataOut  read data; 0 unless Read hits one of this block's addresses
//   ack      one-cycle acknowledge, the cycle after a strobe's first cycle
module la_trig_capture #(
  parameter int          DW     = 32,
  parameter int          AW     = 10,
  parameter logic [7:0]  MYAD   = 8'hFF,
  parameter logic [7:0]  TRIGAD = 8'hFE,
  parameter logic [7:0]  CONTAD = 8'hFD,
  parameter logic [7:0]  MASKAD = 8'hFC,
  parameter logic [7:0]  POSTAD = 8'hFB,
  parameter logic [7:0]  STATAD = 8'hFA
) (
  input  logic          rdclk,
  input  logic          rst,
  input  logic [DW-1:0] Data,
  input  logic [31:0]   DataIn,
  input  logic [7:0]    Address,
  input  logic          Read,
  input  logic          Write,
  output logic [31:0]   DataOut,
  output logic          ack
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [31:0] PMAX    = 32'(DEPTH - 1);
  localparam logic [AW:0] FULLCNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} st_t;
  st_t st, st_nx;

  logic [DW-1:0] mem [DEPTH];
  logic [31:0]   trigval, mask, post_r;
  logic          arm, edge_md;
  logic [AW-1:0] wr_ptr, rd_ptr, trig_addr, cnt;
  logic [AW:0]   remaining;
  logic          wrapped, forced, have_prev, prev_match;
  logic          acc_d, rd_my_d;

  // ---- com-link decode: only the first cycle of a strobe acts ----
  logic hit, acc, first, wr_ctl, clr, arm_on, arm_off, force_t;
  assign hit     = Address inside {MYAD, TRIGAD, CONTAD, MASKAD, POSTAD, STATAD};
  assign acc     = (Read | Write) & hit;
  assign first   = acc & ~acc_d;
  assign wr_ctl  = first & Write & (Address == CONTAD);
  assign clr     = wr_ctl & DataIn[1];
  assign arm_off = wr_ctl & ~DataIn[1] & ~DataIn[0];
  assign arm_on  = wr_ctl & ~DataIn[1] & DataIn[0] & ~arm;
  // FORCE only counts on a write that keeps ARM set (bit0=0 would disarm).
  assign force_t = wr_ctl & ~DataIn[1] & DataIn[0] & DataIn[2];

  // ---- capture / trigger ----
  logic          capture, match, hw_trig, trig, last_post, done_go, wrap_nx, pop;
  logic [AW-1:0] wr_nx, post_ld;
  assign capture   = ((st == ARMED) | (st == POST)) & ~clr & ~arm_off;
  assign match     = ((Data ^ trigval[DW-1:0]) & mask[DW-1:0]) == '0;
  // Edge needs a previous captured sample, so the first one after arm never fires.
  assign hw_trig   = edge_md ? (match & have_prev & ~prev_match) : match;
  assign trig      = (st == ARMED) & capture & (hw_trig | force_t);
  assign post_ld   = (post_r >= PMAX) ? '1 : post_r[AW-1:0];
  assign last_post = (st == POST) & capture & (cnt == AW'(1));
  assign done_go   = (trig & (post_ld == '0)) | last_post;
  assign wr_nx     = wr_ptr + 1'b1;
  assign wrap_nx   = wrapped | (wr_ptr == '1);
  assign pop       = rd_my_d & ~Read & (st == DONE) & (remaining != '0);

  always_ff @(posedge rdclk or negedge rst)
    if (!rst) st <= IDLE;
    else      st <= st_nx;

  always_comb begin
    st_nx = st;
    if (clr || arm_off)  st_nx = IDLE;
    else if (arm_on)     st_nx = ARMED;
    else if (trig)       st_nx = (post_ld == '0) ? DONE : POST;
    else if (last_post)  st_nx = DONE;
  end

  // Sample memory is never cleared.
  always_ff @(posedge rdclk)
    if (capture) mem[wr_ptr] <= Data;

  // ---- com-link registers, strobe tracking, ack ----
  always_ff @(posedge rdclk or negedge rst) begin
    if (!rst) begin
      trigval <= '0; mask <= '0; post_r <= '0; arm <= 1'b0; edge_md <= 1'b0;
      acc_d <= 1'b0; rd_my_d <= 1'b0; ack <= 1'b0;
    end else begin
      acc_d   <= acc;
      rd_my_d <= Read & (Address == MYAD);
      ack     <= first;
      if (first & Write) begin
        case (Address)
          TRIGAD: trigval <= DataIn;
          MASKAD: mask    <= DataIn;
          POSTAD: post_r  <= DataIn;
          CONTAD: begin
            arm     <= DataIn[0] & ~DataIn[1];
            edge_md <= DataIn[3];
          end
          default: ;
        endcase
      end
    end
  end

  // ---- pointers, counters, readout window ----
  always_ff @(posedge rdclk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0; rd_ptr <= '0; trig_addr <= '0; cnt <= '0; remaining <= '0;
      wrapped <= 1'b0; forced <= 1'b0; have_prev <= 1'b0; prev_match <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0; rd_ptr <= '0; trig_addr <= '0; cnt <= '0; remaining <= '0;
      wrapped <= 1'b0; forced <= 1'b0; have_prev <= 1'b0; prev_match <= 1'b0;
    end else if (arm_off) begin
      remaining <= '0;
    end else if (arm_on) begin
      wr_ptr <= '0; wrapped <= 1'b0; forced <= 1'b0; have_prev <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr     <= wr_nx;
        wrapped    <= wrap_nx;
        have_prev  <= 1'b1;
        prev_match <= match;
        if (trig) begin
          trig_addr <= wr_ptr;
          forced    <= force_t;
          cnt       <= post_ld;
        end else if (st == POST) begin
          cnt <= cnt - 1'b1;
        end
        // Oldest sample sits at the next write slot once the buffer has wrapped.
        if (done_go) begin
          rd_ptr    <= wrap_nx ? wr_nx : '0;
          remaining <= wrap_nx ? FULLCNT : {1'b0, wr_nx};
        end
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // ---- read mux ----
  logic [31:0] rd_word, stat;
  always_comb begin
    rd_word = '0;
    rd_word[DW-1:0] = mem[rd_ptr];
    stat = '0;
    stat[1:0]        = st;
    stat[2]          = wrapped;
    stat[3]          = forced;
    stat[4 +: AW+1]  = remaining;
    stat[20 +: AW]   = trig_addr;
    DataOut = '0;
    if (Read) begin
      case (Address)
        MYAD:    if (st == DONE && remaining != '0) DataOut = rd_word;
        CONTAD:  DataOut = {28'b0, edge_md, 2'b0, arm};
        TRIGAD:  DataOut = trigval;
        MASKAD:  DataOut = mask;
        POSTAD:  DataOut = post_r;
        STATAD:  DataOut = stat;
        default: DataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_la_trig_capture.sv
// Bench for la_trig_capture (DW=16, AW=4). For each capture run the expected
// trigger index, window length and readout contents are computed directly
// from the sample array, then compared against status and popped samples.
module tb_la_trig_capture;
  localparam int DW = 16, AW = 4, DEPTH = 16;
  localparam logic [7:0] MYAD = 8'hFF, TRIGAD = 8'hFE, CONTAD = 8'hFD,
                         MASKAD = 8'hFC, POSTAD = 8'hFB, STATAD = 8'hFA;

  logic          rdclk = 1'b0;
  logic          rst;
  logic [DW-1:0] Data;
  logic [31:0]   DataIn;
  logic [7:0]    Address;
  logic          Read, Write;
  logic [31:0]   DataOut;
  logic          ack;

  int checks = 0, failures = 0;
  logic [15:0] smp [96];

  la_trig_capture #(.DW(DW), .AW(AW)) dut (
    .rdclk(rdclk), .rst(rst), .Data(Data), .DataIn(DataIn), .Address(Address),
    .Read(Read), .Write(Write), .DataOut(DataOut), .ack(ack)
  );

  always #5 rdclk = ~rdclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge rdclk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    Address = a; DataIn = d; Write = 1'b1;
    tick; chk("wr_ack", 32'(ack), 1);
    Write = 1'b0;
    tick; chk("wr_ack_once", 32'(ack), 0);
  endtask

  // Hold Read for len cycles, checking data every cycle and a single ack.
  task automatic rdchk(input string tag, input logic [7:0] a, input int len, input logic [31:0] exp);
    Address = a; Read = 1'b1; #1;
    for (int c = 0; c < len; c++) begin
      chk(tag, DataOut, exp);
      tick;
      chk({tag, "_ack"}, 32'(ack), (c == 0) ? 1 : 0);
    end
    Read = 1'b0;
    tick;
  endtask

  function automatic bit mt(logic [15:0] d, logic [15:0] tv, logic [15:0] mk);
    return ((d ^ tv) & mk) == 16'h0;
  endfunction

  // smp[] holds the probe stream; smp[0] is the first sample after arm.
  task automatic run_cap(input bit edg, input logic [15:0] tv, input logic [15:0] mk,
                         input int post, input int fidx, input int rdlen);
    int trig, pc, total, rem, s0, len;
    bit wrp, frc, nat;
    logic [31:0] es, ctl;
    trig = -1;
    for (int i = 0; i < 64; i++) begin
      if (edg) nat = (i > 0) && mt(smp[i], tv, mk) && !mt(smp[i-1], tv, mk);
      else     nat = mt(smp[i], tv, mk);
      if (nat || i == fidx) begin trig = i; break; end
    end
    pc    = (post > DEPTH-1) ? DEPTH-1 : post;
    total = trig + pc + 1;
    wrp   = total >= DEPTH;
    rem   = wrp ? DEPTH : total;
    s0    = total - rem;
    frc   = (trig == fidx);
    es = '0;
    es[31:20] = 12'(trig % DEPTH);
    es[15:4]  = 12'(rem);
    es[3] = frc; es[2] = wrp; es[1:0] = 2'd3;

    wr(TRIGAD, 32'(tv)); wr(MASKAD, 32'(mk)); wr(POSTAD, 32'(post));
    rdchk("rb_post", POSTAD, 1, 32'(post));
    ctl = {28'b0, edg, 3'b001};
    Address = CONTAD; DataIn = ctl; Write = 1'b1;
    tick; chk("arm_ack", 32'(ack), 1);
    Write = 1'b0;
    for (int i = 0; i < total + 3; i++) begin
      Data = smp[i];
      if (i == fidx) begin Address = CONTAD; DataIn = ctl | 32'h4; Write = 1'b1; end
      tick;
      Write = 1'b0;
    end
    tick;
    rdchk("stat_done", STATAD, 1, es);
    for (int j = 0; j < rem; j++) begin
      len = (rdlen == 0) ? int'($urandom_range(1, 4)) : rdlen;
      rdchk("pop", MYAD, len, 32'(smp[s0 + j]));
    end
    rdchk("stat_empty", STATAD, 1, es & ~32'h0000_FFF0);
    rdchk("empty_rd", MYAD, 1, 0);
    wr(CONTAD, 32'h2);
    rdchk("stat_clr", STATAD, 1, 0);
  endtask

  initial begin
    rst = 1'b0; Data = '0; DataIn = '0; Address = '0; Read = 1'b0; Write = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;

    // Reset state
    rdchk("rst_stat", STATAD, 1, 0);
    rdchk("rst_my", MYAD, 3, 0);
    rdchk("rst_trig", TRIGAD, 1, 0);

    // Control readback: CLEAR/FORCE read back as 0
    wr(CONTAD, 32'h8);
    rdchk("rb_ctl", CONTAD, 1, 32'h8);
    wr(CONTAD, 32'hE);
    rdchk("rb_ctl_sc", CONTAD, 1, 32'h8);
    wr(MASKAD, 32'h1234_5678);
    rdchk("rb_mask", MASKAD, 1, 32'h1234_5678);

    // Level trigger on 0x0020, POST=3, counting probe
    for (int i = 0; i < 96; i++) smp[i] = 16'(i);
    run_cap(1'b0, 16'h0020, 16'hFFFF, 3, 90, 0);
    // POST=20 clamps to DEPTH-1; trigger sample is the oldest read
    run_cap(1'b0, 16'h0020, 16'hFFFF, 20, 90, 1);

    // Edge mode: bit0 high at arm, then toggles
    for (int i = 0; i < 96; i++) smp[i] = 16'((i << 4) | ((i < 3) ? 1 : (i + 1) % 2));
    run_cap(1'b1, 16'h0001, 16'h0001, 2, 90, 0);

    // FORCE after 5 samples, no match, POST=0, 4-cycle reads
    for (int i = 0; i < 96; i++) smp[i] = 16'(i);
    run_cap(1'b0, 16'hFFFF, 16'hFFFF, 0, 5, 4);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      logic [15:0] mk;
      for (int i = 0; i < 96; i++) smp[i] = 16'($urandom);
      mk = 16'((1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15)));
      run_cap(1'($urandom % 2), 16'($urandom), mk, int'($urandom_range(0, 20)),
              int'($urandom_range(1, 60)), 0);
    end

    // Async reset during POST
    wr(TRIGAD, 32'h3); wr(MASKAD, 32'hFFFF); wr(POSTAD, 32'd15);
    Address = CONTAD; DataIn = 32'h1; Write = 1'b1;
    tick; Write = 1'b0;
    for (int i = 0; i < 8; i++) begin Data = 16'(i); tick; end
    #2 rst = 1'b0;
    #1;
    chk("rstpost_ack", 32'(ack), 0);
    chk("rstpost_idle_out", DataOut, 0);
    Address = STATAD; Read = 1'b1; #1;
    chk("rstpost_stat", DataOut, 0);
    Address = TRIGAD; #1;
    chk("rstpost_trig", DataOut, 0);
    Address = MYAD; #1;
    chk("rstpost_my", DataOut, 0);
    Read = 1'b0;
    tick;
    rst = 1'b1;
    tick;

    // ARM written 0 mid-ARMED
    wr(TRIGAD, 32'hFFFF); wr(MASKAD, 32'hFFFF); wr(POSTAD, 32'd0);
    Address = CONTAD; DataIn = 32'h1; Write = 1'b1;
    tick; Write = 1'b0;
    Data = '0;
    for (int i = 0; i < 5; i++) tick;
    rdchk("armed_stat", STATAD, 1, 32'h1);
    wr(CONTAD, 32'h0);
    rdchk("disarm_stat", STATAD, 1, 0);
    rdchk("disarm_my", MYAD, 1, 0);
    rdchk("disarm_ctl", CONTAD, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
